// File: rtl/spart.sv
// Special-purpose UART: processor bus interface, programmable baud divisor,
// 8N1 transmitter and 8N1 receiver with a single-byte receive buffer.
module spart #(
    parameter logic [15:0] DEFAULT_DIV = 16'd10416
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_ERR} rx_state_t;

    logic        wr_en, rd_en;
    logic [7:0]  rd_data;
    logic [15:0] div_q, div_d, eff_div, bit_len_m1, half_m1;

    tx_state_t   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tbr_q, tbr_d, tx_load;

    rx_state_t   rx_state_q, rx_state_d;
    logic [1:0]  rx_sync_q, rx_sync_d;
    logic        rx_prev_q, rx_prev_d, rx_in;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d, rx_buf_q, rx_buf_d;
    logic        rda_q, rda_d;

    assign wr_en      = iocs & ~iorw;
    assign rd_en      = iocs & iorw;
    assign eff_div    = (div_q < 16'd2) ? 16'd2 : div_q;
    assign bit_len_m1 = eff_div - 16'd1;
    assign half_m1    = (eff_div >> 1) - 16'd1;
    assign rx_in      = rx_sync_q[1];

    always_comb begin
        rd_data = 8'h00;
        case (ioaddr)
            2'b00: rd_data = rx_buf_q;
            2'b01: rd_data = {6'b0, tbr_q, rda_q};
            2'b10: rd_data = div_q[7:0];
            2'b11: rd_data = div_q[15:8];
            default: rd_data = 8'h00;
        endcase
    end

    assign databus = rd_en ? rd_data : 8'hzz;

    always_comb begin
        div_d = div_q;
        if (wr_en && ioaddr == 2'b10) div_d[7:0]  = databus;
        if (wr_en && ioaddr == 2'b11) div_d[15:8] = databus;
    end

    // A load can only be accepted while idle or in the final STOP cycle,
    // so it overrides whatever the bit timer would have done.
    always_comb begin
        tx_load    = wr_en && (ioaddr == 2'b00) && tbr_q;
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tbr_d      = tbr_q;
        case (tx_state_q)
            TX_IDLE: ;
            TX_START: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = bit_len_m1;
                    tx_bit_d   = 3'd0;
                end else tx_cnt_d = tx_cnt_q - 16'd1;
            end
            TX_DATA: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_cnt_d   = bit_len_m1;
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
                end else tx_cnt_d = tx_cnt_q - 16'd1;
            end
            TX_STOP: begin
                if (tx_cnt_q == 16'd1) tbr_d = 1'b1;
                if (tx_cnt_q == 16'd0) tx_state_d = TX_IDLE;
                else tx_cnt_d = tx_cnt_q - 16'd1;
            end
        endcase
        if (tx_load) begin
            tx_state_d = TX_START;
            tx_cnt_d   = bit_len_m1;
            tx_shift_d = databus;
            tbr_d      = 1'b0;
        end
    end

    always_comb begin
        case (tx_state_q)
            TX_START: txd = 1'b0;
            TX_DATA:  txd = tx_shift_q[0];
            default:  txd = 1'b1;
        endcase
    end

    // Receive: the load case is applied after the read-clear so a byte
    // landing on the same edge as a buffer read leaves rda set.
    always_comb begin
        rx_sync_d  = {rx_sync_q[0], rxd};
        rx_prev_d  = rx_in;
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_buf_d   = rx_buf_q;
        rda_d      = rda_q;
        if (rd_en && ioaddr == 2'b00) rda_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_in) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = half_m1;
                end
            end
            RX_START: begin
                if (rx_cnt_q == 16'd0) begin
                    if (rx_in) rx_state_d = RX_IDLE;
                    else begin
                        rx_state_d = RX_DATA;
                        rx_cnt_d   = bit_len_m1;
                        rx_bit_d   = 3'd0;
                    end
                end else rx_cnt_d = rx_cnt_q - 16'd1;
            end
            RX_DATA: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_shift_d = {rx_in, rx_shift_q[7:1]};
                    rx_cnt_d   = bit_len_m1;
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end else rx_cnt_d = rx_cnt_q - 16'd1;
            end
            RX_STOP: begin
                if (rx_cnt_q == 16'd0) begin
                    if (rx_in) begin
                        rx_buf_d   = rx_shift_q;
                        rda_d      = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else rx_state_d = RX_ERR;
                end else rx_cnt_d = rx_cnt_q - 16'd1;
            end
            RX_ERR:  if (rx_in) rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q      <= DEFAULT_DIV;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= 16'd0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            tbr_q      <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_sync_q  <= 2'b11;
            rx_prev_q  <= 1'b1;
            rx_cnt_q   <= 16'd0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_buf_q   <= 8'h00;
            rda_q      <= 1'b0;
        end else begin
            div_q      <= div_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tbr_q      <= tbr_d;
            rx_state_q <= rx_state_d;
            rx_sync_q  <= rx_sync_d;
            rx_prev_q  <= rx_prev_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_buf_q   <= rx_buf_d;
            rda_q      <= rda_d;
        end
    end

    assign rda = rda_q;
    assign tbr = tbr_q;
endmodule

// File: tb/tb_spart.sv
// Scenario bench for spart: bus registers, tx framing, rx framing/overrun,
// read/load collision, divisor clamp and mid-frame reset.
module tb_spart;
    logic       clk = 1'b0;
    logic       rst, iocs, iorw, rxd, rda, tbr, txd, drv_en;
    logic [1:0] ioaddr;
    logic [7:0] drv_data;
    wire  [7:0] databus;
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] rx_exp_q[$];
    logic [7:0] tx_exp_q[$];
    logic [7:0] last_rx;

    assign databus = drv_en ? drv_data : 8'hzz;
    always #5 clk = ~clk;

    spart #(.DEFAULT_DIV(16'd10416)) dut (
        .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
        .databus(databus), .rda(rda), .tbr(tbr), .txd(txd), .rxd(rxd)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        iocs = 1'b1; iorw = 1'b0; ioaddr = a; drv_data = d; drv_en = 1'b1;
        tick();
        iocs = 1'b0; drv_en = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        iocs = 1'b1; iorw = 1'b1; ioaddr = a;
        @(negedge clk);
        d = databus;
        tick();
        iocs = 1'b0; iorw = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop_bit, input int div);
        rxd = 1'b0;
        repeat (div) tick();
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (div) tick();
        end
        rxd = stop_bit;
        repeat (div) tick();
        rxd = 1'b1;
    endtask

    task automatic wait_rda(input int max_cyc);
        int c;
        c = 0;
        while (rda !== 1'b1 && c < max_cyc) begin
            tick();
            c++;
        end
        n_tests++;
        if (rda !== 1'b1) begin
            n_fail++;
            $display("FAIL rda_timeout: rda=%b want 1 within %0d cycles", rda, max_cyc);
        end
    endtask

    // Checks txd and tbr every cycle of one frame; optional mid-frame writes.
    task automatic tx_frame(input logic [7:0] d, input int div, input bit inject);
        logic [7:0] exp;
        logic       exp_txd;
        int         n, b;
        n = 10 * div;
        n_tests++;
        if (tbr !== 1'b1) begin
            n_fail++; $display("FAIL tx_pre_tbr: got %b want 1", tbr);
        end
        tx_exp_q.push_back(d);
        bus_write(2'b00, d);
        exp = tx_exp_q.pop_front();
        for (int k = 1; k <= n; k++) begin
            b = (k - 1) / div;
            exp_txd = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : exp[3'(b - 1)];
            n_tests++;
            if (txd !== exp_txd) begin
                n_fail++; $display("FAIL tx_bit: byte %h cycle %0d txd=%b want %b", exp, k, txd, exp_txd);
            end
            n_tests++;
            if (tbr !== (k == n)) begin
                n_fail++; $display("FAIL tx_tbr: byte %h cycle %0d tbr=%b want %b", exp, k, tbr, (k == n));
            end
            if (k < n) begin
                if (inject && k == 10)      bus_write(2'b00, 8'h11);
                else if (inject && k == 15) bus_write(2'b01, 8'hFF);
                else                        tick();
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] v;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        n_tests++;
        if ({txd, tbr, rda} !== 3'b110) begin
            n_fail++; $display("FAIL reset_flags: txd,tbr,rda=%b want 110", {txd, tbr, rda});
        end
        iorw = 1'b1; ioaddr = 2'b10; drv_data = 8'h00; drv_en = 1'b1;
        @(negedge clk);
        n_tests++;
        if (databus !== 8'h00) begin
            n_fail++; $display("FAIL bus_release: databus=%h want 00 with iocs low", databus);
        end
        tick();
        drv_en = 1'b0; iorw = 1'b0;
        bus_read(2'b10, v);
        n_tests++;
        if (v !== 8'hB0) begin n_fail++; $display("FAIL reset_div_lo: got %h want b0", v); end
        bus_read(2'b11, v);
        n_tests++;
        if (v !== 8'h28) begin n_fail++; $display("FAIL reset_div_hi: got %h want 28", v); end
        bus_read(2'b00, v);
        n_tests++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL reset_rxbuf: got %h want 00", v); end
    endtask

    task automatic test_tx();
        logic [7:0] v;
        bus_write(2'b10, 8'h04);
        bus_write(2'b11, 8'h00);
        bus_read(2'b10, v);
        n_tests++;
        if (v !== 8'h04) begin n_fail++; $display("FAIL div_wr_lo: got %h want 04", v); end
        bus_read(2'b11, v);
        n_tests++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL div_wr_hi: got %h want 00", v); end
        tx_frame(8'h55, 4, 1'b0);
        tick();
    endtask

    task automatic test_tx_busy();
        logic [7:0] v;
        tx_frame(8'h96, 4, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick();
            n_tests++;
            if ({txd, tbr} !== 2'b11) begin
                n_fail++; $display("FAIL tx_ignored_write: idle cycle %0d txd,tbr=%b want 11", i, {txd, tbr});
            end
        end
        bus_read(2'b01, v);
        n_tests++;
        if (v !== 8'h02) begin n_fail++; $display("FAIL status_idle: got %h want 02", v); end
        bus_read(2'b10, v);
        n_tests++;
        if (v !== 8'h04) begin n_fail++; $display("FAIL div_after_01: got %h want 04", v); end
    endtask

    task automatic test_tx_back_to_back();
        tx_frame(8'hA5, 4, 1'b0);
        tx_frame(8'h3C, 4, 1'b0);
        tick();
    endtask

    task automatic test_rx();
        logic [7:0] v, exp;
        rx_exp_q.push_back(8'hA3);
        send_rx(8'hA3, 1'b1, 4);
        wait_rda(20);
        bus_read(2'b01, v);
        n_tests++;
        if (v !== 8'h03) begin n_fail++; $display("FAIL rx_status: got %h want 03", v); end
        bus_read(2'b00, v);
        exp = rx_exp_q.pop_front();
        last_rx = exp;
        n_tests++;
        if (v !== exp) begin n_fail++; $display("FAIL rx_data: got %h want %h", v, exp); end
        n_tests++;
        if (rda !== 1'b0) begin n_fail++; $display("FAIL rx_rda_clear: rda=%b want 0", rda); end
    endtask

    task automatic test_rx_framing();
        logic [7:0] v, exp;
        send_rx(8'h3C, 1'b0, 4);
        repeat (12) tick();
        n_tests++;
        if (rda !== 1'b0) begin n_fail++; $display("FAIL frame_err_rda: rda=%b want 0", rda); end
        bus_read(2'b00, v);
        n_tests++;
        if (v !== last_rx) begin n_fail++; $display("FAIL frame_err_buf: got %h want %h", v, last_rx); end
        rx_exp_q.push_back(8'h7E);
        send_rx(8'h7E, 1'b1, 4);
        wait_rda(20);
        bus_read(2'b00, v);
        exp = rx_exp_q.pop_front();
        last_rx = exp;
        n_tests++;
        if (v !== exp) begin n_fail++; $display("FAIL rx_after_err: got %h want %h", v, exp); end
    endtask

    task automatic test_rx_overrun();
        logic [7:0] v, exp;
        rx_exp_q.push_back(8'h01);
        rx_exp_q.push_back(8'h02);
        send_rx(8'h01, 1'b1, 4);
        send_rx(8'h02, 1'b1, 4);
        repeat (3) tick();
        n_tests++;
        if (rda !== 1'b1) begin n_fail++; $display("FAIL overrun_rda: rda=%b want 1", rda); end
        void'(rx_exp_q.pop_front());
        bus_read(2'b00, v);
        exp = rx_exp_q.pop_front();
        last_rx = exp;
        n_tests++;
        if (v !== exp) begin n_fail++; $display("FAIL overrun_data: got %h want %h", v, exp); end
    endtask

    // The second frame's stop sample lands on the edge that ends the read.
    task automatic test_rx_read_collision();
        logic [7:0] v, exp;
        rx_exp_q.push_back(8'hC5);
        send_rx(8'hC5, 1'b1, 4);
        wait_rda(20);
        repeat (4) tick();
        rx_exp_q.push_back(8'h6B);
        send_rx(8'h6B, 1'b1, 4);
        bus_read(2'b00, v);
        exp = rx_exp_q.pop_front();
        n_tests++;
        if (v !== exp) begin n_fail++; $display("FAIL collide_old: got %h want %h", v, exp); end
        n_tests++;
        if (rda !== 1'b1) begin n_fail++; $display("FAIL collide_rda: rda=%b want 1", rda); end
        bus_read(2'b00, v);
        exp = rx_exp_q.pop_front();
        last_rx = exp;
        n_tests++;
        if (v !== exp) begin n_fail++; $display("FAIL collide_new: got %h want %h", v, exp); end
    endtask

    task automatic test_div_min();
        bus_write(2'b10, 8'h01);
        tx_frame(8'hC4, 2, 1'b0);
        tick();
        bus_write(2'b10, 8'h04);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] v;
        send_rx(8'h5A, 1'b1, 4);
        wait_rda(20);
        bus_write(2'b00, 8'h00);
        repeat (15) tick();
        n_tests++;
        if ({txd, tbr} !== 2'b00) begin
            n_fail++; $display("FAIL mid_frame: txd,tbr=%b want 00", {txd, tbr});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rx_exp_q.delete();
        n_tests++;
        if ({txd, tbr, rda} !== 3'b110) begin
            n_fail++; $display("FAIL rst_mid_frame: txd,tbr,rda=%b want 110", {txd, tbr, rda});
        end
        repeat (6) tick();
        n_tests++;
        if (txd !== 1'b1) begin n_fail++; $display("FAIL rst_txd_idle: txd=%b want 1", txd); end
        bus_read(2'b10, v);
        n_tests++;
        if (v !== 8'hB0) begin n_fail++; $display("FAIL rst_div: got %h want b0", v); end
        bus_read(2'b00, v);
        n_tests++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL rst_rxbuf: got %h want 00", v); end
    endtask

    initial begin
        rst = 1'b1; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
        rxd = 1'b1; drv_en = 1'b0; drv_data = 8'h00; last_rx = 8'h00;
        test_reset();
        test_tx();
        test_tx_busy();
        test_tx_back_to_back();
        test_rx();
        test_rx_framing();
        test_rx_overrun();
        test_rx_read_collision();
        test_div_min();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
